// File: rtl/riscv_pkg.sv
// Shared RISC-V core types and constants.
// Fetch-stage state encoding, PC select codes and reset defaults.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        PC_4   = 2'd0,
        PC_BEQ = 2'd1,
        PC_J   = 2'd2
    } PC_sel_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        DRAIN = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/next_pc_sel.sv
// Redirect detection and target selection for the fetch stage.
// Targets are forced to word alignment.
module next_pc_sel
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  PC_sel_e         pc_sel,
    input  logic            branch_eq,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] jump_target,
    output logic            redirect,
    output logic [XLEN-1:0] target
);

    always_comb begin
        redirect = 1'b0;
        target   = jump_target;
        unique case (pc_sel)
            PC_J: begin
                redirect = 1'b1;
                target   = jump_target;
            end
            PC_BEQ: begin
                redirect = branch_eq;
                target   = branch_target;
            end
            default: begin
                redirect = 1'b0;
                target   = jump_target;
            end
        endcase
        target[1:0] = 2'b00;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, imem handshake FSM, skid buffer
// and the IF_ID pipeline register.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  PC_sel_e         pc_sel,
    input  logic            branch_eq,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] jump_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     if_id_instr,
    output logic [XLEN-1:0] if_id_pc,
    output logic            if_id_valid
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
    logic [31:0]     if_id_instr_q, if_id_instr_d;
    logic            if_id_valid_q, if_id_valid_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;
    logic [31:0]     skid_instr_q, skid_instr_d;
    logic            skid_valid_q, skid_valid_d;
    logic            redirect;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc_inc;

    next_pc_sel #(.XLEN(XLEN)) u_next_pc_sel (
        .pc_sel        (pc_sel),
        .branch_eq     (branch_eq),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .redirect      (redirect),
        .target        (target)
    );

    assign pc_inc      = pc_q + XLEN'(4);
    assign imem_req    = (state_q == ISSUE) && !redirect;
    assign imem_addr   = pc_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_valid = if_id_valid_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        skid_pc_d     = skid_pc_q;
        skid_instr_d  = skid_instr_q;
        skid_valid_d  = skid_valid_q;

        if (redirect && state_q != IDLE) begin
            pc_d          = target;
            if_id_instr_d = NOP_INSTR;
            if_id_pc_d    = '0;
            if_id_valid_d = 1'b0;
            skid_valid_d  = 1'b0;
            // One response is still owed unless it lands this cycle
            unique case (state_q)
                WAIT, DRAIN: state_d = imem_rvalid ? ISSUE : DRAIN;
                default:     state_d = ISSUE;
            endcase
        end else begin
            unique case (state_q)
                IDLE: state_d = ISSUE;
                ISSUE: begin
                    if (imem_gnt) state_d = WAIT;
                end
                WAIT: begin
                    if (imem_rvalid && stall) begin
                        skid_instr_d = imem_rdata;
                        skid_pc_d    = pc_q;
                        skid_valid_d = 1'b1;
                        state_d      = HOLD;
                    end else if (imem_rvalid) begin
                        if_id_instr_d = imem_rdata;
                        if_id_pc_d    = pc_q;
                        if_id_valid_d = 1'b1;
                        pc_d          = pc_inc;
                        state_d       = ISSUE;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        if_id_instr_d = skid_instr_q;
                        if_id_pc_d    = skid_pc_q;
                        if_id_valid_d = skid_valid_q;
                        skid_valid_d  = 1'b0;
                        pc_d          = pc_inc;
                        state_d       = ISSUE;
                    end
                end
                DRAIN: begin
                    if (imem_rvalid) state_d = ISSUE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            if_id_pc_q    <= '0;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
            skid_pc_q     <= '0;
            skid_instr_q  <= NOP_INSTR;
            skid_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
            skid_pc_q     <= skid_pc_d;
            skid_instr_q  <= skid_instr_d;
            skid_valid_q  <= skid_valid_d;
        end
    end

endmodule
